// File: rtl/seq_divider.sv
// 4-bit unsigned restoring divider, one quotient bit per cycle.
// Start/busy/done handshake; results held until the next completion.
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] q_q, q_d;
  logic [3:0] d_q, d_d;
  logic [4:0] r_q, r_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [4:0] shifted;
  logic [5:0] sum;
  logic [4:0] trial;
  logic       no_borrow;
  logic       accept;

  // Trial subtraction as add of inverted divisor plus carry-in.
  always_comb begin
    shifted   = {r_q[3:0], q_q[3]};
    sum       = {1'b0, shifted}
              + {1'b0, ~{1'b0, d_q}}
              + 6'd1;
    trial     = sum[4:0];
    no_borrow = sum[5];
    accept    = start
              && (state_q == IDLE
              ||  state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= 4'd0;
      d_q     <= 4'd0;
      r_q     <= 5'd0;
      cnt_q   <= 2'd0;
      quo_q   <= 4'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept)
          state_d = (divisor == 4'd0)
                  ? DONE : CALC;
        else
          state_d = IDLE;
      end
      CALC: begin
        if (cnt_q == 2'd3)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d   = q_q;
    d_d   = d_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      q_d   = dividend;
      d_d   = divisor;
      r_d   = 5'd0;
      cnt_d = 2'd0;
      if (divisor == 4'd0) begin
        quo_d = 4'hF;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == CALC) begin
      r_d   = no_borrow ? trial : shifted;
      q_d   = {q_q[2:0], no_borrow};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        quo_d = {q_q[2:0], no_borrow};
        rem_d = r_d[3:0];
        dbz_d = 1'b0;
      end
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    unique case (state_q)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, corner sequences,
// exhaustive back-to-back sweep and randomized ops vs. a model.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Reference: plain integer division with the
  // divide-by-zero convention.
  task automatic model(input  logic [3:0] a,
                       input  logic [3:0] b,
                       output logic [3:0] q,
                       output logic [3:0] r,
                       output logic       z,
                       output int         lat);
    int ia, ib;
    ia = a;
    ib = b;
    if (ib == 0) begin
      q = 4'hF; r = a; z = 1'b1; lat = 0;
    end else begin
      q   = 4'(ia / ib);
      r   = 4'(ia % ib);
      z   = 1'b0;
      lat = 4;
    end
  endtask

  // Called at a negedge; returns at the negedge where done
  // is first seen (or after a bounded wait).
  task automatic run_op(input  logic [3:0] a,
                        input  logic [3:0] b,
                        input  bit         jit,
                        output logic [3:0] gq,
                        output logic [3:0] gr,
                        output logic       gz,
                        output int         lat,
                        output int         bsy);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bsy   = 0;
    while (!done && lat < 8) begin
      if (busy) bsy++;
      if (jit) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) lat = 99;
    gq = quotient;
    gr = remainder;
    gz = div_by_zero;
  endtask

  task automatic check_op(input string      tag,
                          input logic [3:0] a,
                          input logic [3:0] b,
                          input logic [3:0] gq,
                          input logic [3:0] gr,
                          input logic       gz,
                          input int         lat,
                          input int         bsy);
    logic [3:0] eq, er;
    logic       ez;
    int         el;
    model(a, b, eq, er, ez, el);
    chk($sformatf("%s %0d/%0d quo", tag, a, b), 8'(gq), 8'(eq));
    chk($sformatf("%s %0d/%0d rem", tag, a, b), 8'(gr), 8'(er));
    chk($sformatf("%s %0d/%0d dbz", tag, a, b), 8'(gz), 8'(ez));
    chk($sformatf("%s %0d/%0d lat", tag, a, b), 8'(lat), 8'(el));
    chk($sformatf("%s %0d/%0d bsy", tag, a, b), 8'(bsy), 8'(el));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    logic [3:0] gq, gr;
    logic       gz;
    int         lat, bsy, n;

    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0, 4};
    tbl[1] = '{4'd7,  4'd0,  4'hF,  4'd7,  1'b1, 0};
    tbl[2] = '{4'd9,  4'd2,  4'd4,  4'd1,  1'b0, 4};
    tbl[3] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0, 4};
    tbl[4] = '{4'd3,  4'd5,  4'd0,  4'd3,  1'b0, 4};
    tbl[5] = '{4'd14, 4'd3,  4'd4,  4'd2,  1'b0, 4};
    tbl[6] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0, 4};
    tbl[7] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0, 4};
    tbl[8] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0, 4};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset quo",  8'(quotient),    8'd0);
    chk("reset rem",  8'(remainder),   8'd0);
    chk("reset busy", 8'(busy),        8'd0);
    chk("reset done", 8'(done),        8'd0);
    chk("reset dbz",  8'(div_by_zero), 8'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0,
             gq, gr, gz, lat, bsy);
      chk($sformatf("tbl%0d quo", i), 8'(gq), 8'(tbl[i].q));
      chk($sformatf("tbl%0d rem", i), 8'(gr), 8'(tbl[i].r));
      chk($sformatf("tbl%0d dbz", i), 8'(gz), 8'(tbl[i].z));
      chk($sformatf("tbl%0d lat", i), 8'(lat), 8'(tbl[i].lat));
      chk($sformatf("tbl%0d bsy", i), 8'(bsy), 8'(tbl[i].lat));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d done once", i), 8'(done), 8'd0);
      chk($sformatf("tbl%0d idle busy", i), 8'(busy), 8'd0);
      chk($sformatf("tbl%0d hold quo", i),
          8'(quotient), 8'(tbl[i].q));
    end

    // start held high with new operands during CALC
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd2;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd15;
    divisor  = 4'd15;
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ign lat", 8'(n),         8'd4);
    chk("ign quo", 8'(quotient),  8'd4);
    chk("ign rem", 8'(remainder), 8'd1);
    chk("ign dbz", 8'(div_by_zero), 8'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ign done once", 8'(done), 8'd0);
    chk("ign hold rem", 8'(remainder), 8'd1);

    // back-to-back: second start accepted in the DONE cycle
    run_op(4'd15, 4'd1, 1'b0, gq, gr, gz, lat, bsy);
    check_op("b2b first", 4'd15, 4'd1, gq, gr, gz, lat, bsy);
    run_op(4'd3, 4'd5, 1'b0, gq, gr, gz, lat, bsy);
    check_op("b2b second", 4'd3, 4'd5, gq, gr, gz, lat, bsy);

    // asynchronous reset in the middle of CALC
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst quo",  8'(quotient),    8'd0);
    chk("arst rem",  8'(remainder),   8'd0);
    chk("arst busy", 8'(busy),        8'd0);
    chk("arst done", 8'(done),        8'd0);
    chk("arst dbz",  8'(div_by_zero), 8'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("arst held done", 8'(done), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("arst no late done", 8'(done), 8'd0);
    run_op(4'd14, 4'd3, 1'b0, gq, gr, gz, lat, bsy);
    check_op("post rst", 4'd14, 4'd3, gq, gr, gz, lat, bsy);

    // exhaustive, back-to-back
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b0, gq, gr, gz, lat, bsy);
        check_op("sweep", 4'(a), 4'(b), gq, gr, gz, lat, bsy);
      end
    end

    // random operands, gaps, and input noise during CALC
    for (int k = 0; k < 200; k++) begin
      logic [3:0] ra, rb;
      int gap;
      ra  = 4'($urandom);
      rb  = 4'($urandom_range(0, 15));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(ra, rb, 1'b1, gq, gr, gz, lat, bsy);
      check_op("rand", ra, rb, gq, gr, gz, lat, bsy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
